// File: rtl/puf_ctrl_pkg.sv
// Shared state encoding, error-bit indices and sizing helpers for the PUF response collector.
package puf_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_RUN     = 2'd1;
    localparam state_t ST_COMPARE = 2'd2;
    localparam state_t ST_OUTPUT  = 2'd3;

    localparam int ERR_DUP     = 0;
    localparam int ERR_TIE     = 1;
    localparam int ERR_TIMEOUT = 2;
    localparam int ERR_MISSING = 3;
    localparam int ERR_BITS    = 4;

    function automatic int avg_width(input int cnt_bits, input int avg_shift);
        return cnt_bits - avg_shift;
    endfunction

endpackage

// File: rtl/puf_avg_bank.sv
// Per-loop average registers with a valid mask; flags writes that repeat a loop or fall out of range.
module puf_avg_bank
    import puf_ctrl_pkg::*;
#(
    parameter int NUM_LOOPS = 4,
    parameter int AVG_W     = avg_width(32, 12),
    parameter int SEL_W     = $clog2(NUM_LOOPS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 wr_en,
    input  logic [SEL_W-1:0]     wr_idx,
    input  logic [AVG_W-1:0]     wr_data,
    input  logic [SEL_W-1:0]     rd_idx_a,
    input  logic [SEL_W-1:0]     rd_idx_b,
    output logic [AVG_W-1:0]     rd_data_a,
    output logic [AVG_W-1:0]     rd_data_b,
    output logic [NUM_LOOPS-1:0] valid,
    output logic                 dup_hit
);

    localparam logic [SEL_W:0] LOOPS_LIM = (SEL_W + 1)'(NUM_LOOPS);

    logic [AVG_W-1:0] avg [NUM_LOOPS];
    logic             in_range;

    assign in_range  = ({1'b0, wr_idx} < LOOPS_LIM);
    // An out-of-range index counts as a duplicate so the run is marked unreliable.
    assign dup_hit   = wr_en & (in_range ? valid[wr_idx] : 1'b1);
    assign rd_data_a = avg[rd_idx_a];
    assign rd_data_b = avg[rd_idx_b];

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid <= '0;
            for (int i = 0; i < NUM_LOOPS; i++) begin
                avg[i] <= '0;
            end
        end else if (clear) begin
            valid <= '0;
        end else if (wr_en && in_range) begin
            avg[wr_idx]   <= wr_data;
            valid[wr_idx] <= 1'b1;
        end
    end

endmodule

// File: rtl/puf_response_collector.sv
// Host-side controller for the TERO evaluation FSM: request handshake, counter capture/averaging,
// pairwise compare and a held valid/ready response carrying an error flag.
module puf_response_collector
    import puf_ctrl_pkg::*;
#(
    parameter int NUM_LOOPS      = 4,
    parameter int CHALLENGE_BITS = 4,
    parameter int CNT_BITS       = 32,
    parameter int AVG_SHIFT      = 12,
    parameter int TIMEOUT_BITS   = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [CHALLENGE_BITS-1:0]    req_challenge,
    output logic                         fsm_start,
    output logic [CHALLENGE_BITS-1:0]    fsm_challenge,
    input  logic                         fsm_done,
    input  logic                         fsm_store,
    input  logic [$clog2(NUM_LOOPS)-1:0] fsm_select,
    input  logic [CNT_BITS-1:0]          cnt_value,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [NUM_LOOPS/2-1:0]       resp_bits,
    output logic [CHALLENGE_BITS-1:0]    resp_challenge,
    output logic                         resp_error
);

    localparam int SEL_W = $clog2(NUM_LOOPS);
    localparam int AVG_W = avg_width(CNT_BITS, AVG_SHIFT);
    localparam int NP    = NUM_LOOPS / 2;
    localparam int PW    = $clog2(NP + 1);

    state_t                  state;
    logic [TIMEOUT_BITS-1:0] wdog;
    logic [TIMEOUT_BITS-1:0] wdog_next;
    logic [PW-1:0]           pair;
    logic [ERR_BITS-1:0]     errs;
    logic [NUM_LOOPS-1:0]    valid;
    logic                    dup_hit;
    logic                    accept;
    logic                    store_en;
    logic [SEL_W-1:0]        rd_a;
    logic [SEL_W-1:0]        rd_b;
    logic [AVG_W-1:0]        avg_a;
    logic [AVG_W-1:0]        avg_b;
    logic                    unused_cnt_lsbs;

    assign req_ready       = (state == ST_IDLE) && !fsm_done;
    assign accept          = req_valid && req_ready;
    assign store_en        = fsm_store && (state == ST_RUN);
    assign wdog_next       = wdog + 1'b1;
    assign rd_a            = SEL_W'({pair, 1'b0});
    assign rd_b            = rd_a | SEL_W'(1);
    assign unused_cnt_lsbs = ^cnt_value[AVG_SHIFT-1:0];

    puf_avg_bank #(
        .NUM_LOOPS (NUM_LOOPS),
        .AVG_W     (AVG_W),
        .SEL_W     (SEL_W)
    ) u_bank (
        .clk       (clk),
        .reset     (reset),
        .clear     (accept),
        .wr_en     (store_en),
        .wr_idx    (fsm_select),
        .wr_data   (cnt_value[CNT_BITS-1:AVG_SHIFT]),
        .rd_idx_a  (rd_a),
        .rd_idx_b  (rd_b),
        .rd_data_a (avg_a),
        .rd_data_b (avg_b),
        .valid     (valid),
        .dup_hit   (dup_hit)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= ST_IDLE;
            fsm_start      <= 1'b0;
            fsm_challenge  <= '0;
            resp_challenge <= '0;
            resp_valid     <= 1'b0;
            resp_bits      <= '0;
            resp_error     <= 1'b0;
            wdog           <= '0;
            pair           <= '0;
            errs           <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        fsm_challenge  <= req_challenge;
                        resp_challenge <= req_challenge;
                        resp_bits      <= '0;
                        wdog           <= '0;
                        errs           <= '0;
                        fsm_start      <= 1'b1;
                        state          <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    wdog <= wdog_next;
                    if (dup_hit) errs[ERR_DUP] <= 1'b1;
                    // Done has priority over a coincident watchdog expiry.
                    if (fsm_done) begin
                        fsm_start <= 1'b0;
                        pair      <= '0;
                        state     <= ST_COMPARE;
                    end else if (&wdog_next) begin
                        errs[ERR_TIMEOUT] <= 1'b1;
                        fsm_start         <= 1'b0;
                        pair              <= '0;
                        state             <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    if (pair == PW'(NP)) begin
                        // Extra cycle folds the last tie result into the error flag.
                        resp_error <= |errs;
                        resp_valid <= 1'b1;
                        state      <= ST_OUTPUT;
                    end else begin
                        if (pair == '0) errs[ERR_MISSING] <= ~&valid;
                        if (avg_a == avg_b) errs[ERR_TIE] <= 1'b1;
                        for (int k = 0; k < NP; k++) begin
                            if (pair == PW'(k)) resp_bits[k] <= (avg_a > avg_b);
                        end
                        pair <= pair + 1'b1;
                    end
                end
                default: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/puf_response_collector.md
Name: puf_response_collector

Overview:
- Host-facing controller wrapped around the TERO evaluation FSM.
- Accepts one challenge per valid/ready request and drives the FSM start/challenge inputs.
- Captures the shared oscillation counter on every store pulse and averages it by shift.
- Compares loop pairs to form the response word, then returns it through a valid/ready response channel with an error flag.

Parameters:
- NUM_LOOPS, 4, number of TERO loops; must be even and ≥2.
- CHALLENGE_BITS, 4, challenge width.
- CNT_BITS, 32, width of the shared oscillation counter.
- AVG_SHIFT, 12, log2(REPETITIONS); the average is cnt_value >> AVG_SHIFT.
- TIMEOUT_BITS, 32, watchdog width; the timeout fires when the counter reaches all-ones.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_challenge  in  CHALLENGE_BITS  challenge to evaluate.
- fsm_start  out  1  start to the evaluation FSM (level, registered).
- fsm_challenge  out  CHALLENGE_BITS  latched challenge to the FSM.
- fsm_done  in  1  FSM done.
- fsm_store  in  1  FSM store-response pulse.
- fsm_select  in  $clog2(NUM_LOOPS)  loop index valid with fsm_store.
- cnt_value  in  CNT_BITS  shared counter value valid with fsm_store.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_bits  out  NUM_LOOPS/2  response bits.
- resp_challenge  out  CHALLENGE_BITS  challenge that produced resp_bits.
- resp_error  out  1  response is unreliable.

Behaviour:
- Reset (reset=0):
  - state=IDLE.
  - All outputs 0 except req_ready. req_ready is combinational: 1 when IDLE and fsm_done=0.
  - Valid mask, averages, pair index and watchdog are cleared.
- Reset mid-operation: same values next cycle; fsm_start drops immediately.
- State IDLE:
  - Handshake when req_valid & req_ready.
  - Latch the challenge into fsm_challenge and resp_challenge.
  - Clear valid mask and watchdog; go to RUN.
  - req_ready is low when fsm_done=1, so the previous run's DONE must clear before a new start.
- State RUN:
  - fsm_start=1 from the first RUN cycle (registered, one cycle after the handshake). Watchdog increments each cycle.
  - Capture on fsm_store=1, same cycle, with no additional sampling delay. The FSM holds the data for one cycle only.
    - avg[fsm_select] <= cnt_value >> AVG_SHIFT, width CNT_BITS-AVG_SHIFT.
    - Set valid[fsm_select].
    - If valid[fsm_select] was already set, set the sticky err_dup and overwrite the average.
  - fsm_select ≥ NUM_LOOPS with fsm_store: ignored, sticky err_dup set.
  - fsm_done=1: fsm_start<=0, go to COMPARE.
  - Watchdog all-ones with no done: set err_timeout, fsm_start<=0, go to COMPARE.
  - If fsm_done and the timeout coincide, done wins; err_timeout stays 0.
- State COMPARE:
  - One pair per cycle, k = 0..NUM_LOOPS/2-1.
  - resp_bits[k] = (avg[2k] > avg[2k+1]), unsigned. A tie gives 0 and sets sticky err_tie.
  - After the last pair, go to OUTPUT.
  - Latency from fsm_done sampled high to resp_valid high is NUM_LOOPS/2+1 cycles.
- State OUTPUT:
  - resp_valid=1 and resp_bits/resp_challenge/resp_error stay stable until resp_ready=1.
  - resp_error = err_dup | err_tie | err_timeout | ~&valid.
  - On resp_valid & resp_ready: resp_valid<=0, go to IDLE.
  - A fsm_store pulse outside RUN is ignored and does not set an error.
- fsm_challenge holds its value from the handshake until the next handshake.

Decomposition:
- Package puf_ctrl_pkg:
  - State enum {IDLE, RUN, COMPARE, OUTPUT}, 2 bits.
  - Localparam function avg_width(CNT_BITS, AVG_SHIFT).
  - Error-bit index constants (ERR_DUP, ERR_TIE, ERR_TIMEOUT, ERR_MISSING).
- Sub-module puf_avg_bank:
  - NUM_LOOPS×avg_width register array plus valid mask and dup detect.
  - Interfaces: clear, write enable, index, data; two read ports for the pair comparison.
- Top-level FSM: handshakes, watchdog, compare sequencing.

Test Plan:
- Nominal: NUM_LOOPS=4, AVG_SHIFT=12, challenge 4'hA; stores (sel0,0x0010_0000), (sel1,0x000F_F000), (sel2,0x0008_0000), (sel3,0x0009_0000), then done -> resp_bits=2'b01, resp_error=0, resp_challenge=4'hA, resp_valid 3 cycles after done.
- Tie: sel0 and sel1 both 0x0002_0FFF (avg 0x20 each) -> bit0=0, resp_error=1.
- Missing/duplicate: sel2 never stored -> resp_error=1. Separate run with sel1 stored twice -> resp_error=1 and the last value used.
- Backpressure: resp_ready low for 5 cycles -> outputs stable, req_ready=0. fsm_done held high after response -> req_ready stays 0 until done falls.
- Timeout: TIMEOUT_BITS=4, no done -> fsm_start falls after 15 RUN cycles, resp_error=1.
- Reset mid-RUN: reset=0 for one cycle after two stores -> next cycle fsm_start=0, resp_valid=0; the next run's valid mask starts empty.
